// File: rtl/btn_in_multi.sv
// Multi-channel push-button front end: synchroniser, tick-sampled debounce, edge pulses,
// long-press detection and auto-repeat per channel, sharing one prescaler tick.
//
// state   | meaning
// IDLE    | debounced level released
// PRESSED | level pressed, counting ticks toward the long-press threshold
// HELD    | long press reported, counting ticks between auto-repeat pulses
module btn_in_multi #(
    parameter int CH           = 4,
    parameter int BIT_SIZE     = 20,
    parameter int STABLE       = 2,
    parameter int ACTIVE_LOW   = 1,
    parameter int LONG_TICKS   = 64,
    parameter int REPEAT_TICKS = 8
) (
    input  logic          clk,
    input  logic          i_sclr,
    input  logic [CH-1:0] i_bin,
    output logic [CH-1:0] o_level,
    output logic [CH-1:0] o_press,
    output logic [CH-1:0] o_release,
    output logic [CH-1:0] o_long,
    output logic [CH-1:0] o_repeat,
    output logic          o_tick
);
    localparam int SW   = $clog2(STABLE + 1);
    localparam int MAXT = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int HW   = (MAXT < 1) ? 1 : $clog2(MAXT + 1);
    localparam logic [SW-1:0] STABLE_W = SW'(STABLE);
    localparam logic [HW-1:0] LONG_W   = HW'(LONG_TICKS);
    localparam logic [HW-1:0] REP_W    = HW'(REPEAT_TICKS);
    localparam logic          IDLE_PIN = (ACTIVE_LOW != 0);

    logic [BIT_SIZE-1:0] presc;

    always_ff @(posedge clk or posedge i_sclr) begin
        if (i_sclr) presc <= '0;
        else        presc <= presc + BIT_SIZE'(1);
    end

    assign o_tick = &presc;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
        state_t        state, state_n;
        logic          s1, s2, p, differ, flip, rise, fall;
        logic          level, press, rel, long_q, rpt_q, long_n, rpt_n;
        logic [SW-1:0] cnt, cnt_n, cnt_inc;
        logic [HW-1:0] hold, hold_n, hold_inc;

        // Sync flops reset to the released pin value so reset never looks like a press.
        always_ff @(posedge clk or posedge i_sclr) begin
            if (i_sclr) begin
                s1 <= IDLE_PIN;
                s2 <= IDLE_PIN;
            end else begin
                s1 <= i_bin[g];
                s2 <= s1;
            end
        end

        assign p = IDLE_PIN ? ~s2 : s2;

        always_comb begin
            cnt_inc  = cnt + SW'(1);
            hold_inc = hold + HW'(1);
            differ   = p ^ level;
            flip     = o_tick & differ & (cnt_inc == STABLE_W);
            rise     = flip & ~level;
            fall     = flip & level;
            cnt_n    = cnt;
            if (o_tick) cnt_n = (differ && !flip) ? cnt_inc : '0;

            state_n = state;
            hold_n  = hold;
            long_n  = 1'b0;
            rpt_n   = 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state_n = PRESSED;
                        hold_n  = '0;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        state_n = IDLE;
                        hold_n  = '0;
                    end else if (o_tick && LONG_TICKS != 0) begin
                        if (hold_inc == LONG_W) begin
                            state_n = HELD;
                            long_n  = 1'b1;
                            hold_n  = '0;
                        end else begin
                            hold_n = hold_inc;
                        end
                    end
                end
                HELD: begin
                    if (fall) begin
                        state_n = IDLE;
                        hold_n  = '0;
                    end else if (o_tick && REPEAT_TICKS != 0) begin
                        if (hold_inc == REP_W) begin
                            rpt_n  = 1'b1;
                            hold_n = '0;
                        end else begin
                            hold_n = hold_inc;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    hold_n  = '0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge i_sclr) begin
            if (i_sclr) begin
                state  <= IDLE;
                hold   <= '0;
                cnt    <= '0;
                level  <= 1'b0;
                press  <= 1'b0;
                rel    <= 1'b0;
                long_q <= 1'b0;
                rpt_q  <= 1'b0;
            end else begin
                state  <= state_n;
                hold   <= hold_n;
                cnt    <= cnt_n;
                level  <= level ^ flip;
                press  <= rise;
                rel    <= fall;
                long_q <= long_n;
                rpt_q  <= rpt_n;
            end
        end

        assign o_level[g]   = level;
        assign o_press[g]   = press;
        assign o_release[g] = rel;
        assign o_long[g]    = long_q;
        assign o_repeat[g]  = rpt_q;
    end

endmodule

// File: tb/tb_btn_in_multi.sv
// Bench for btn_in_multi: tick-level behavioural model checked every cycle, directed
// scenarios with hand-computed latencies, then randomized pin activity.
module tb_btn_in_multi;
    localparam int CH     = 2;
    localparam int BS     = 2;
    localparam int STABLE = 2;
    localparam int LONG   = 4;
    localparam int REP    = 2;

    logic       clk    = 1'b0;
    logic       i_sclr = 1'b1;
    logic [1:0] i_bin  = 2'b11;
    logic [1:0] o_level, o_press, o_release, o_long, o_repeat;
    logic       o_tick;

    int checks   = 0;
    int failures = 0;
    int rel_cnt0 = 0;

    btn_in_multi #(
        .CH(CH), .BIT_SIZE(BS), .STABLE(STABLE), .ACTIVE_LOW(1),
        .LONG_TICKS(LONG), .REPEAT_TICKS(REP)
    ) dut (
        .clk(clk), .i_sclr(i_sclr), .i_bin(i_bin),
        .o_level(o_level), .o_press(o_press), .o_release(o_release),
        .o_long(o_long), .o_repeat(o_repeat), .o_tick(o_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: pressed-ness of the pin as seen two clocks ago, counted in whole ticks.
    bit [1:0] m_lvl, e_press, e_rel, e_long, e_rpt, h1, h2;
    int       run [2];
    int       held [2];
    int       m_cyc;

    always @(posedge clk or posedge i_sclr) begin : model
        bit tk;
        bit flip;
        if (i_sclr) begin
            m_cyc = 0; m_lvl = '0; h1 = '0; h2 = '0;
            e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0;
            for (int c = 0; c < CH; c++) begin
                run[c]  = 0;
                held[c] = 0;
            end
        end else begin
            tk = (m_cyc % 4 == 3);
            e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0;
            for (int c = 0; c < CH; c++) begin
                flip = 1'b0;
                if (tk) begin
                    if (h2[c] != m_lvl[c]) begin
                        run[c]++;
                        if (run[c] == STABLE) flip = 1'b1;
                    end else begin
                        run[c] = 0;
                    end
                    if (flip) begin
                        run[c] = 0;
                        if (m_lvl[c]) e_rel[c] = 1'b1;
                        else begin
                            e_press[c] = 1'b1;
                            held[c] = 0;
                        end
                        m_lvl[c] = ~m_lvl[c];
                    end else if (m_lvl[c]) begin
                        held[c]++;
                        if (held[c] == LONG) e_long[c] = 1'b1;
                        else if (held[c] > LONG && (held[c] - LONG) % REP == 0) e_rpt[c] = 1'b1;
                    end
                end
                h2[c] = h1[c];
                h1[c] = ~i_bin[c];
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        check("level",   int'(o_level),   int'(m_lvl));
        check("press",   int'(o_press),   int'(e_press));
        check("release", int'(o_release), int'(e_rel));
        check("long",    int'(o_long),    int'(e_long));
        check("repeat",  int'(o_repeat),  int'(e_rpt));
        check("tick",    int'(o_tick),    int'(m_cyc % 4 == 3));
        if (o_release[0]) rel_cnt0++;
    end

    // sel: 0 press, 1 release, 2 long, 3 repeat, other tick. n = negedges waited, -1 on timeout.
    task automatic wait_for(input int sel, input int ch, input int maxc, output int n);
        logic [1:0] s;
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            @(negedge clk);
            case (sel)
                0:       s = o_press;
                1:       s = o_release;
                2:       s = o_long;
                3:       s = o_repeat;
                default: s = {2{o_tick}};
            endcase
            if (s[ch]) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_tick();
        int n;
        wait_for(4, 0, 8, n);
        check("tick_seen", int'(n > 0), 1);
    endtask

    initial begin
        int n;
        int rel_snap;
        int dur [2];

        // T1: reset and prescaler phase
        repeat (3) @(negedge clk);
        i_sclr = 1'b0;
        wait_for(4, 0, 8, n);  check("t1_first_tick", n, 3);
        wait_for(4, 0, 8, n);  check("t1_tick_period", n, 4);

        // T3: glitch spanning one tick sample
        wait_tick();
        i_bin[0] = 1'b0;
        repeat (4) @(negedge clk);
        i_bin[0] = 1'b1;
        wait_for(0, 0, 24, n); check("t3_no_press", n, -1);
        check("t3_level", int'(o_level[0]), 0);

        // T2: press channel 0
        wait_tick();
        i_bin = 2'b10;
        wait_for(0, 0, 20, n); check("t2_press_latency", n, 9);
        check("t2_level", int'(o_level[0]), 1);
        check("t2_ch1_quiet", int'(o_press[1]), 0);

        // T4: hold then release
        wait_for(2, 0, 40, n); check("t4_long", n, 16);
        wait_for(3, 0, 20, n); check("t4_repeat1", n, 8);
        wait_for(3, 0, 20, n); check("t4_repeat2", n, 8);
        wait_tick();
        i_bin[0] = 1'b1;
        wait_for(1, 0, 20, n); check("t4_release", n, 9);
        wait_for(3, 0, 40, n); check("t4_no_repeat", n, -1);

        // T5: simultaneous channels
        wait_tick();
        i_bin = 2'b00;
        wait_for(0, 0, 20, n); check("t5_press_latency", n, 9);
        check("t5_press_both", int'(o_press), 3);
        wait_tick();
        i_bin = 2'b11;
        wait_for(1, 0, 20, n); check("t5_release_latency", n, 9);
        check("t5_release_both", int'(o_release), 3);

        // T6: reset while held
        wait_tick();
        i_bin = 2'b10;
        wait_for(0, 0, 20, n); check("t6_press", n, 9);
        wait_for(2, 0, 40, n); check("t6_long", n, 16);
        rel_snap = rel_cnt0;
        @(negedge clk);
        #2 i_sclr = 1'b1;
        #1 check("t6_outputs_cleared",
                 int'({o_level, o_press, o_release, o_long, o_repeat, o_tick}), 0);
        @(negedge clk);
        i_sclr = 1'b0;
        wait_for(0, 0, 20, n); check("t6_fresh_press", n, 8);
        check("t6_no_release", rel_cnt0, rel_snap);

        // Randomized pin activity, including short glitches and one reset
        i_bin = 2'b11;
        dur[0] = 1;
        dur[1] = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                dur[c]--;
                if (dur[c] <= 0) begin
                    i_bin[c] = ~i_bin[c];
                    dur[c] = int'($urandom_range(1, 60));
                end
            end
            if (cyc == 1500) i_sclr = 1'b1;
            if (cyc == 1502) i_sclr = 1'b0;
        end
        i_bin = 2'b11;
        repeat (60) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
